// File: rtl/fpadd_rr_arbiter.sv
// fpadd_rr_arbiter: round-robin sharing of one multi-cycle fpadd unit among NREQ requesters.
// Optional macro FPADD_ARB_TIMEOUT_EN adds a WAIT-state timeout that returns a NaN with rsp_err set.
module fpadd_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_sum,
    output logic              rsp_err,
    output logic              fpa_start,
    output logic [31:0]       fpa_a,
    output logic [31:0]       fpa_b,
    input  logic [31:0]       fpa_sum,
    input  logic              fpa_done,
    output logic              busy,
    output logic [15:0]       op_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (IDW != $clog2(NREQ) || NREQ < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("fpadd_rr_arbiter: invalid NREQ/IDW/TIMEOUT");
    end

    state_t          state, state_next;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt;
    logic            found;
    logic            timed_out;

    // first valid requester at or after rr_ptr, wrapping mod NREQ
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                found = 1'b1;
                gnt   = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next-state; done is only looked at in WAIT because it may still be high from the previous op during ISSUE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  state_next = found ? ISSUE : IDLE;
            ISSUE: state_next = WAIT;
            WAIT:  state_next = (fpa_done || timed_out) ? RESP : WAIT;
            RESP:  state_next = rsp_ready ? IDLE : RESP;
        endcase
    end

    // handshake outputs decoded from state
    always_comb begin
        req_ready = (state == IDLE && found) ? (NREQ'(1) << gnt) : '0;
        fpa_start = state == ISSUE;
        rsp_valid = state == RESP;
        busy      = state != IDLE;
    end

    // operand capture on accept, result capture on completion, bookkeeping on response handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpa_a    <= '0;
            fpa_b    <= '0;
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rr_ptr   <= '0;
            op_count <= '0;
        end else begin
            if (state == IDLE && found) begin
                fpa_a  <= req_a[32*gnt +: 32];
                fpa_b  <= req_b[32*gnt +: 32];
                rsp_id <= gnt;
            end
            if (state == WAIT && (fpa_done || timed_out))
                rsp_sum <= fpa_done ? fpa_sum : 32'h7FC00000;
            if (state == RESP && rsp_ready) begin
                op_count <= op_count + 16'd1;
                rr_ptr   <= IDW'((int'(rsp_id) + 1) % NREQ);
            end
        end
    end

`ifdef FPADD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    assign timed_out = state == WAIT && !fpa_done && wait_cnt == CW'(TIMEOUT - 1);

    // WAIT cycle counter, zero outside WAIT so it restarts on every entry; error flag for the substituted result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
            if (state == WAIT && (fpa_done || timed_out))
                rsp_err <= !fpa_done;
        end
    end
`else
    assign timed_out = 1'b0;
    assign rsp_err   = 1'b0;
`endif
endmodule
